dut_intf: RTL and testbench
===========================

Name: dut_intf

Overview:
- Byte-stream packet summing block with four ready/enable method interfaces: din, len, dout, cfg.
- Input bytes are buffered in a FIFO. A length command tells the engine how many bytes to consume. The mod-256 sum of those bytes is returned on dout.
- The cfg port gives register access for enable, flush, status, a packet counter and a scratch register.
- Sits behind a thin test wrapper that drives all ports directly.

Parameters:
- FIFO_DEPTH, 8, depth of the din byte FIFO (power of two, at most 8).

Ports:
- CLK  in  1  single clock, rising-edge.
- RST_N  in  1  asynchronous, active-high reset; 1 = in reset (the port name is kept; the polarity is fixed as active-high).
- din_value  in  8  input data byte.
- din_en  in  1  push din_value.
- din_rdy  out  1  FIFO can accept a byte.
- dout_en  in  1  pop the result.
- dout_value  out  8  result byte.
- dout_rdy  out  1  result valid.
- len_value  in  8  packet length in bytes.
- len_en  in  1  issue a length command.
- len_rdy  out  1  engine can accept a length command.
- cfg_address  in  8  register address.
- cfg_data_in  in  32  write data.
- cfg_op  in  1  1 = write, 0 = read.
- cfg_en  in  1  cfg access strobe.
- cfg_data_out  out  32  read data (registered).
- cfg_rdy  out  1  cfg port ready.

Behaviour:
- Handshake: a transfer happens on a rising edge where en && rdy. An en asserted while rdy=0 is ignored. All rdy outputs are 0 while reset is asserted.
- Reset values: FIFO empty, engine idle, dout_rdy=0, dout_value=0, cfg_data_out=0, CTRL.enable=1, PKT_COUNT=0, SCRATCH=0.
- The first edge after reset deasserts restores normal rdy values.
- din_rdy = (FIFO count < FIFO_DEPTH).
  - A push and an engine pop in the same cycle are both performed.
  - A push while full cannot happen, because rdy is 0.
- len_rdy = enable && !busy && !dout_rdy.
  - Accepting len_value=L>0 loads the remaining-count with L and the accumulator with 0, and sets busy.
  - L=0 is accepted and discarded: no packet, no state change.
- Engine: while busy && enable && FIFO not empty, it pops one byte per cycle, adds it to the accumulator (mod 256) and decrements the remaining-count.
  - On the cycle the last byte is consumed, busy clears.
  - On the next edge, dout_value = sum and dout_rdy=1.
  - Bytes already in the FIFO are therefore consumed back-to-back.
- dout_value and dout_rdy hold until dout_en.
  - A pop clears dout_rdy and increments PKT_COUNT (32-bit, wraps).
  - A new len is not accepted until the pop has happened.
- With enable=0 the engine pauses mid-packet, preserving its state; din pushes still happen.
- cfg_rdy = 1 whenever out of reset. Register map (word registers, one per address):
  - 0x00 CTRL (rw).
    - bit0 = enable.
    - bit1 = flush: write-1 pulse, reads 0. Flush empties the FIFO, clears busy, the accumulator and dout_rdy. It leaves PKT_COUNT unchanged.
  - 0x01 STATUS (ro).
    - [3:0] FIFO count; [4] busy; [5] dout_rdy; [15:8] remaining-count.
    - Other bits 0.
  - 0x02 PKT_COUNT (rw). A write of any value clears it to 0.
  - 0x03 SCRATCH (rw), 32-bit.
  - Other addresses read 0; writes to them are ignored.
- Read: cfg_en && cfg_op==0 latches the register value into cfg_data_out on that edge. The value is visible the next cycle and holds until the next read.
- Write: takes effect on the edge.
- Simultaneous events:
  - A flush in the same cycle as a din push or a len accept: flush wins and the push/len is dropped.
  - A PKT_COUNT clear in the same cycle as a dout pop: the clear wins and the result is 0.
- Reset mid-operation aborts everything immediately (asynchronous) to the reset values.

Test Plan:
- Reset, then push bytes 0x01, 0x02, 0x03, 0x04, then len=4 → dout_rdy high within 6 cycles, dout_value=0x0A; pop → dout_rdy=0; read 0x02 → 1.
- Push 0xFF, 0x02 with len=2 → dout_value=0x01 (wrap). Issue len=3 with only 2 bytes in the FIFO → no result until the third byte 0x05 is pushed, then 0x06.
- Push 8 bytes without len → din_rdy=0; STATUS[3:0]=8. len=1 → one byte pops and din_rdy returns to 1.
- Write CTRL=0 mid-packet → engine stalls, STATUS busy=1. Write CTRL=1 → packet completes with the correct sum.
- Write CTRL=0x3 (flush) with 5 bytes buffered and a packet busy → STATUS reads 0; the next len=1 followed by push 0x07 → dout_value=0x07.
- Write SCRATCH=0xDEADBEEF, then read → 0xDEADBEEF. Read 0x10 → 0. Assert reset mid-packet → all rdy=0, and after release STATUS=0 and SCRATCH=0.

Source files
------------

// File: rtl/dut_intf.sv
// Purpose : byte FIFO feeding a mod-256 summing engine, with a small cfg register file.
// Latency : a packet whose bytes are already buffered shows its result L+1 edges after len is accepted.
// Backpressure: din_rdy drops when the FIFO is full; len_rdy drops while busy, paused or holding a result.
//
// Ports:
//   CLK, RST_N (asynchronous, active-high despite the name)
//   din_*  : byte push into the FIFO            len_*  : packet length command
//   dout_* : summed result, held until popped   cfg_*  : register read/write (read data registered)
module dut_intf #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  din_value,
    input  logic        din_en,
    output logic        din_rdy,
    input  logic        dout_en,
    output logic [7:0]  dout_value,
    output logic        dout_rdy,
    input  logic [7:0]  len_value,
    input  logic        len_en,
    output logic        len_rdy,
    input  logic [7:0]  cfg_address,
    input  logic [31:0] cfg_data_in,
    input  logic        cfg_op,
    input  logic        cfg_en,
    output logic [31:0] cfg_data_out,
    output logic        cfg_rdy
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          live_q;
    logic          busy_q, busy_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    acc_q, acc_d;
    // Finished sum waiting one edge before it is published on dout.
    logic          pend_q, pend_d;
    logic [7:0]    pend_sum_q, pend_sum_d;
    logic          dout_rdy_q, dout_rdy_d;
    logic [7:0]    dout_value_q, dout_value_d;
    logic          enable_q, enable_d;
    logic [31:0]   pkt_q, pkt_d;
    logic [31:0]   scratch_q, scratch_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          cfg_wr, cfg_rd, flush, push, len_acc, eng_pop, dout_pop;
    logic [7:0]    head;
    logic [31:0]   rdata;

    // Every rdy stays low until the first edge after reset is released.
    assign din_rdy      = live_q && (cnt_q < DEPTH_C);
    assign len_rdy      = live_q && enable_q && !busy_q && !dout_rdy_q;
    assign cfg_rdy      = live_q;
    assign dout_rdy     = dout_rdy_q;
    assign dout_value   = dout_value_q;
    assign cfg_data_out = rdata_q;

    assign cfg_wr   = cfg_en && cfg_op && live_q;
    assign cfg_rd   = cfg_en && !cfg_op && live_q;
    assign flush    = cfg_wr && (cfg_address == 8'h00) && cfg_data_in[1];
    assign push     = din_en && din_rdy && !flush;
    assign len_acc  = len_en && len_rdy && !flush && (len_value != 8'd0);
    assign eng_pop  = busy_q && enable_q && (cnt_q != 4'd0);
    assign dout_pop = dout_en && dout_rdy_q;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        rdata = 32'h0;
        case (cfg_address)
            8'h00:   rdata = {31'h0, enable_q};
            8'h01:   rdata = {16'h0, rem_q, 2'b00, dout_rdy_q, busy_q, cnt_q};
            8'h02:   rdata = pkt_q;
            8'h03:   rdata = scratch_q;
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        busy_d       = busy_q;
        rem_d        = rem_q;
        acc_d        = acc_q;
        pend_d       = 1'b0;
        pend_sum_d   = pend_sum_q;
        dout_rdy_d   = dout_rdy_q;
        dout_value_d = dout_value_q;
        enable_d     = enable_q;
        pkt_d        = pkt_q;
        scratch_d    = scratch_q;
        rdata_d      = rdata_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d = cnt_q + {3'b000, push} - {3'b000, eng_pop};

        if (eng_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            acc_d    = acc_q + head;
            rem_d    = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
                busy_d     = 1'b0;
                pend_d     = 1'b1;
                pend_sum_d = acc_q + head;
            end
        end

        // len_acc implies !busy, so it never collides with an engine pop.
        if (len_acc) begin
            busy_d = 1'b1;
            rem_d  = len_value;
            acc_d  = 8'd0;
        end

        if (pend_q) begin
            dout_rdy_d   = 1'b1;
            dout_value_d = pend_sum_q;
        end
        if (dout_pop) begin
            dout_rdy_d = 1'b0;
            pkt_d      = pkt_q + 32'd1;
        end

        // Register writes come after the pop so a PKT_COUNT clear wins.
        if (cfg_wr) begin
            case (cfg_address)
                8'h00:   enable_d  = cfg_data_in[0];
                8'h02:   pkt_d     = 32'h0;
                8'h03:   scratch_d = cfg_data_in;
                default: ;
            endcase
        end

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = 4'd0;
            busy_d     = 1'b0;
            rem_d      = 8'd0;
            acc_d      = 8'd0;
            pend_d     = 1'b0;
            dout_rdy_d = 1'b0;
        end

        if (cfg_rd) rdata_d = rdata;
    end

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            live_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            rem_q        <= 8'd0;
            acc_q        <= 8'd0;
            pend_q       <= 1'b0;
            pend_sum_q   <= 8'd0;
            dout_rdy_q   <= 1'b0;
            dout_value_q <= 8'd0;
            enable_q     <= 1'b1;
            pkt_q        <= 32'h0;
            scratch_q    <= 32'h0;
            rdata_q      <= 32'h0;
        end else begin
            live_q       <= 1'b1;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            rem_q        <= rem_d;
            acc_q        <= acc_d;
            pend_q       <= pend_d;
            pend_sum_q   <= pend_sum_d;
            dout_rdy_q   <= dout_rdy_d;
            dout_value_q <= dout_value_d;
            enable_q     <= enable_d;
            pkt_q        <= pkt_d;
            scratch_q    <= scratch_d;
            rdata_q      <= rdata_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= din_value;
    end

endmodule

// File: tb/tb_dut_intf.sv
module tb_dut_intf;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  din_value = 8'h0;
    logic        din_en = 1'b0;
    logic        din_rdy;
    logic        dout_en = 1'b0;
    logic [7:0]  dout_value;
    logic        dout_rdy;
    logic [7:0]  len_value = 8'h0;
    logic        len_en = 1'b0;
    logic        len_rdy;
    logic [7:0]  cfg_address = 8'h0;
    logic [31:0] cfg_data_in = 32'h0;
    logic        cfg_op = 1'b0;
    logic        cfg_en = 1'b0;
    logic [31:0] cfg_data_out;
    logic        cfg_rdy;

    dut_intf #(.FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
        .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
        .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
        .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
        .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
    );

    always #5 CLK = ~CLK;

    // Reference model: bytes pushed but not yet claimed by a packet, in order.
    logic [7:0]  stream [$];
    logic [31:0] m_pkt;
    int          passed = 0;
    int          fails  = 0;
    int          total  = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int k;
        k = 0;
        while (!din_rdy && k < 20) begin
            step();
            k++;
        end
        if (!din_rdy) chk("push_timeout", 32'd0, 32'd1);
        else begin
            din_value = b;
            din_en    = 1'b1;
            step();
            din_en    = 1'b0;
            stream.push_back(b);
        end
    endtask

    task automatic send_len(input logic [7:0] l);
        int k;
        k = 0;
        while (!len_rdy && k < 50) begin
            step();
            k++;
        end
        if (!len_rdy) chk("len_timeout", 32'd0, 32'd1);
        else begin
            len_value = l;
            len_en    = 1'b1;
            step();
            len_en    = 1'b0;
        end
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [31:0] d);
        cfg_address = a;
        cfg_data_in = d;
        cfg_op      = 1'b1;
        cfg_en      = 1'b1;
        step();
        cfg_en      = 1'b0;
        cfg_op      = 1'b0;
    endtask

    task automatic cfg_rd(input logic [7:0] a, output logic [31:0] d);
        cfg_address = a;
        cfg_op      = 1'b0;
        cfg_en      = 1'b1;
        step();
        cfg_en      = 1'b0;
        d           = cfg_data_out;
    endtask

    // Waits for a result, compares it with the sum of the next l stream bytes, then pops it.
    task automatic get_result(input int l, input int budget, input string tag);
        logic       seen;
        logic [7:0] e;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (dout_rdy) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen && dout_rdy) seen = 1'b1;
        chk({tag, "_rdy"}, {31'h0, seen}, 32'd1);
        e = 8'h0;
        for (int i = 0; i < l; i++)
            if (stream.size() > 0) e = e + stream.pop_front();
        chk({tag, "_val"}, {24'h0, dout_value}, {24'h0, e});
        if (seen) begin
            dout_en = 1'b1;
            step();
            dout_en = 1'b0;
            m_pkt   = m_pkt + 32'd1;
        end
        chk({tag, "_pop"}, {31'h0, dout_rdy}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          n;

        // Reset behaviour
        m_pkt = 32'h0;
        RST_N = 1'b1;
        #1;
        chk("rst_din_rdy", {31'h0, din_rdy}, 32'd0);
        chk("rst_len_rdy", {31'h0, len_rdy}, 32'd0);
        chk("rst_cfg_rdy", {31'h0, cfg_rdy}, 32'd0);
        step();
        step();
        RST_N = 1'b0;
        #1;
        chk("rel_din_rdy_before_edge", {31'h0, din_rdy}, 32'd0);
        step();
        chk("rel_din_rdy", {31'h0, din_rdy}, 32'd1);
        chk("rel_len_rdy", {31'h0, len_rdy}, 32'd1);
        chk("rel_cfg_rdy", {31'h0, cfg_rdy}, 32'd1);
        chk("rel_dout_rdy", {31'h0, dout_rdy}, 32'd0);
        chk("rel_dout_value", {24'h0, dout_value}, 32'd0);
        chk("rel_cfg_data_out", cfg_data_out, 32'd0);
        cfg_rd(8'h00, rd);
        chk("rel_ctrl", rd, 32'd1);

        // Basic packet
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        send_len(8'd4);
        get_result(4, 6, "basic");
        cfg_rd(8'h02, rd);
        chk("pkt_count_1", rd, m_pkt);

        // Wrap and waiting for a late byte
        push(8'hFF); push(8'h02);
        send_len(8'd2);
        get_result(2, 10, "wrap");
        push(8'hFF); push(8'h02);
        send_len(8'd3);
        repeat (10) step();
        chk("late_no_result", {31'h0, dout_rdy}, 32'd0);
        push(8'h05);
        get_result(3, 10, "late");

        // Zero length is discarded
        send_len(8'd0);
        repeat (3) step();
        chk("len0_dout_rdy", {31'h0, dout_rdy}, 32'd0);
        chk("len0_len_rdy", {31'h0, len_rdy}, 32'd1);
        cfg_rd(8'h01, rd);
        chk("len0_status", rd, 32'd0);

        // Full FIFO
        for (int i = 0; i < 8; i++) push(8'($urandom));
        chk("full_din_rdy", {31'h0, din_rdy}, 32'd0);
        cfg_rd(8'h01, rd);
        chk("full_status_cnt", {28'h0, rd[3:0]}, 32'd8);
        send_len(8'd1);
        step();
        chk("full_din_rdy_back", {31'h0, din_rdy}, 32'd1);
        get_result(1, 10, "full1");
        send_len(8'd7);
        get_result(7, 20, "full7");

        // Pause mid-packet
        send_len(8'd4);
        push(8'h11); push(8'h22);
        cfg_wr(8'h00, 32'h0);
        push(8'h33); push(8'h44);
        repeat (5) step();
        chk("pause_dout_rdy", {31'h0, dout_rdy}, 32'd0);
        cfg_rd(8'h01, rd);
        chk("pause_status", rd, 32'h0000_0212);
        cfg_wr(8'h00, 32'h1);
        get_result(4, 10, "resume");

        // Flush with buffered bytes and a busy packet
        send_len(8'd10);
        push(8'h10); push(8'h20);
        step(); step();
        cfg_wr(8'h00, 32'h0);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        cfg_rd(8'h01, rd);
        chk("preflush_status", rd, 32'h0000_0815);
        cfg_wr(8'h00, 32'h3);
        stream.delete();
        cfg_rd(8'h01, rd);
        chk("flush_status", rd, 32'd0);
        cfg_rd(8'h00, rd);
        chk("flush_ctrl", rd, 32'd1);
        send_len(8'd1);
        push(8'h07);
        get_result(1, 10, "postflush");

        // Registers
        cfg_wr(8'h03, 32'hDEADBEEF);
        cfg_rd(8'h03, rd);
        chk("scratch", rd, 32'hDEADBEEF);
        cfg_wr(8'h10, 32'h1234_5678);
        cfg_rd(8'h10, rd);
        chk("unmapped", rd, 32'd0);
        cfg_rd(8'h02, rd);
        chk("pkt_count", rd, m_pkt);
        cfg_wr(8'h02, 32'hFFFF_FFFF);
        m_pkt = 32'h0;
        cfg_rd(8'h02, rd);
        chk("pkt_clear", rd, m_pkt);

        // Randomized packets
        for (int it = 0; it < 16; it++) begin
            n = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 1) begin
                send_len(8'(n));
                for (int i = 0; i < n; i++) push(8'($urandom));
            end else begin
                for (int i = 0; i < n; i++) push(8'($urandom));
                send_len(8'(n));
            end
            repeat ($urandom_range(0, 3)) step();
            get_result(n, 30, "rand");
        end
        cfg_rd(8'h02, rd);
        chk("rand_pkt_count", rd, m_pkt);

        // Reset mid-packet
        send_len(8'd5);
        push(8'h09); push(8'h0A);
        RST_N = 1'b1;
        #1;
        chk("midrst_din_rdy", {31'h0, din_rdy}, 32'd0);
        chk("midrst_len_rdy", {31'h0, len_rdy}, 32'd0);
        chk("midrst_cfg_rdy", {31'h0, cfg_rdy}, 32'd0);
        chk("midrst_dout_rdy", {31'h0, dout_rdy}, 32'd0);
        stream.delete();
        m_pkt = 32'h0;
        step();
        RST_N = 1'b0;
        step();
        cfg_rd(8'h01, rd);
        chk("midrst_status", rd, 32'd0);
        cfg_rd(8'h03, rd);
        chk("midrst_scratch", rd, 32'd0);
        cfg_rd(8'h02, rd);
        chk("midrst_pkt", rd, m_pkt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
